// File: rtl/cache_miss_controller_if.sv
// CPU, cache-array and memory-side signal bundle for the cache miss controller.
// The master modport is the controller's view; slave is the surrounding system.
interface cache_miss_controller_if #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned BLOCK_WIDTH = 128
);
    // CPU side
    logic                   cpu_read;
    logic                   cpu_write;
    logic [ADDR_WIDTH-1:0]  cpu_addr;
    logic [DATA_WIDTH-1:0]  cpu_wdata;
    logic [DATA_WIDTH-1:0]  cpu_rdata;
    logic                   cpu_done;
    logic                   cpu_stall;
    // Cache array side
    logic                   cache_rd_en;
    logic                   cache_wr_en;
    logic                   cache_fill;
    logic [ADDR_WIDTH-1:0]  cache_addr;
    logic [DATA_WIDTH-1:0]  cache_wdata;
    logic [BLOCK_WIDTH-1:0] cache_fill_data;
    logic                   cache_hit;
    logic [DATA_WIDTH-1:0]  cache_rdata;
    // Memory side
    logic                   mem_rd_req;
    logic                   mem_wr_req;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [DATA_WIDTH-1:0]  mem_wdata;
    logic                   mem_ready;
    logic [BLOCK_WIDTH-1:0] mem_rdata;
    // Statistics
    logic [15:0]            hit_count;
    logic [15:0]            miss_count;

    modport master (
        input  cpu_read, cpu_write, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_done, cpu_stall,
        output cache_rd_en, cache_wr_en, cache_fill, cache_addr, cache_wdata, cache_fill_data,
        input  cache_hit, cache_rdata,
        output mem_rd_req, mem_wr_req, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata,
        output hit_count, miss_count
    );

    modport slave (
        output cpu_read, cpu_write, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_done, cpu_stall,
        input  cache_rd_en, cache_wr_en, cache_fill, cache_addr, cache_wdata, cache_fill_data,
        output cache_hit, cache_rdata,
        input  mem_rd_req, mem_wr_req, mem_addr, mem_wdata,
        output mem_ready, mem_rdata,
        input  hit_count, miss_count
    );
endinterface

// File: rtl/cache_miss_controller.sv
// Blocking cache miss controller: read-allocate refill, write-through with no-write-allocate,
// saturating hit/miss statistics.
module cache_miss_controller #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned BLOCK_WIDTH = 128
) (
    input  logic                    clk,
    input  logic                    reset,
    cache_miss_controller_if.master bus
);
    localparam int unsigned WORDS = BLOCK_WIDTH / DATA_WIDTH;

    typedef enum logic [2:0] {
        StIdle,
        StCompare,
        StRefill,
        StFill,
        StRespond,
        StMemWrite
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   write_q, write_d;
    logic                   done_q, done_d;
    logic [BLOCK_WIDTH-1:0] fill_q, fill_d;
    logic [15:0]            hit_count_q, hit_count_d;
    logic [15:0]            miss_count_q, miss_count_d;
    logic [DATA_WIDTH-1:0]  fill_word;
    logic [ADDR_WIDTH-1:0]  block_addr;
    logic [15:0]            hit_count_inc, miss_count_inc;

    assign block_addr     = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign hit_count_inc  = (hit_count_q == 16'hFFFF) ? hit_count_q : hit_count_q + 16'd1;
    assign miss_count_inc = (miss_count_q == 16'hFFFF) ? miss_count_q : miss_count_q + 16'd1;

    always_comb begin
        fill_word = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (addr_q[1:0] == 2'(i)) begin
                fill_word = fill_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        rdata_d         = rdata_q;
        write_d         = write_q;
        done_d          = 1'b0;
        fill_d          = fill_q;
        hit_count_d     = hit_count_q;
        miss_count_d    = miss_count_q;
        bus.cache_rd_en = 1'b0;
        bus.cache_wr_en = 1'b0;
        bus.cache_fill  = 1'b0;
        bus.mem_rd_req  = 1'b0;
        bus.mem_wr_req  = 1'b0;
        bus.mem_addr    = addr_q;

        unique case (state_q)
            StIdle: begin
                // The cycle carrying cpu_done still sees the finished request held high.
                if (!done_q && (bus.cpu_read || bus.cpu_write)) begin
                    addr_d  = bus.cpu_addr;
                    wdata_d = bus.cpu_wdata;
                    write_d = bus.cpu_write;
                    state_d = StCompare;
                end
            end
            StCompare: begin
                bus.cache_rd_en = 1'b1;
                if (bus.cache_hit) begin
                    hit_count_d = hit_count_inc;
                end else begin
                    miss_count_d = miss_count_inc;
                end
                if (write_q) begin
                    bus.cache_wr_en = bus.cache_hit;
                    state_d         = StMemWrite;
                end else if (bus.cache_hit) begin
                    rdata_d = bus.cache_rdata;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    state_d = StRefill;
                end
            end
            StRefill: begin
                bus.mem_rd_req = 1'b1;
                bus.mem_addr   = block_addr;
                if (bus.mem_ready) begin
                    fill_d  = bus.mem_rdata;
                    state_d = StFill;
                end
            end
            StFill: begin
                bus.cache_fill = 1'b1;
                rdata_d        = fill_word;
                done_d         = 1'b1;
                state_d        = StRespond;
            end
            StRespond: begin
                state_d = StIdle;
            end
            StMemWrite: begin
                bus.mem_wr_req = 1'b1;
                if (bus.mem_ready) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            write_q      <= 1'b0;
            done_q       <= 1'b0;
            fill_q       <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            write_q      <= write_d;
            done_q       <= done_d;
            fill_q       <= fill_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign bus.cpu_rdata       = rdata_q;
    assign bus.cpu_done        = done_q;
    assign bus.cpu_stall       = (state_q != StIdle);
    assign bus.cache_addr      = addr_q;
    assign bus.cache_wdata     = wdata_q;
    assign bus.cache_fill_data = fill_q;
    assign bus.mem_wdata       = wdata_q;
    assign bus.hit_count       = hit_count_q;
    assign bus.miss_count      = miss_count_q;
endmodule

// File: tb/tb_cache_miss_controller.sv
// Directed bench for cache_miss_controller: inputs change and outputs are checked on the
// falling edge; a posedge monitor counts strobes and memory transfers.
module tb_cache_miss_controller;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 128;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cache_miss_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_WIDTH(BW)) bus ();

    cache_miss_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_WIDTH(BW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Pre-edge values seen at each rising edge.
    int fill_pulses   = 0;
    int wr_en_pulses  = 0;
    int rd_req_cycles = 0;
    int wr_xfers      = 0;
    int both_req      = 0;
    always @(posedge clk) begin
        if (bus.cache_fill)                  fill_pulses   <= fill_pulses + 1;
        if (bus.cache_wr_en)                 wr_en_pulses  <= wr_en_pulses + 1;
        if (bus.mem_rd_req)                  rd_req_cycles <= rd_req_cycles + 1;
        if (bus.mem_wr_req && bus.mem_ready) wr_xfers      <= wr_xfers + 1;
        if (bus.mem_rd_req && bus.mem_wr_req) both_req     <= both_req + 1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    localparam logic [31:0] D0 = 32'h1111_0000;
    localparam logic [31:0] D1 = 32'h2222_1111;
    localparam logic [31:0] D2 = 32'h3333_2222;
    localparam logic [31:0] D3 = 32'h4444_3333;

    int wr_en_base;
    int wr_xfer_base;
    int rd_req_base;

    initial begin
        bus.cpu_read    = 1'b0;
        bus.cpu_write   = 1'b0;
        bus.cpu_addr    = '0;
        bus.cpu_wdata   = '0;
        bus.cache_hit   = 1'b0;
        bus.cache_rdata = '0;
        bus.mem_ready   = 1'b0;
        bus.mem_rdata   = '0;

        // Reset state
        reset = 1'b0;
        cyc(); cyc();
        check("rst_stall", bus.cpu_stall, 0);
        check("rst_done", bus.cpu_done, 0);
        check("rst_hit", bus.hit_count, 0);
        check("rst_miss", bus.miss_count, 0);
        check("rst_rdata", bus.cpu_rdata, 0);
        check("rst_memrd", bus.mem_rd_req, 0);
        check("rst_memwr", bus.mem_wr_req, 0);
        check("rst_rden", bus.cache_rd_en, 0);

        // Read hit, issued in the first cycle after reset release
        reset = 1'b1;
        bus.cpu_read    = 1'b1;
        bus.cpu_addr    = 32'h5;
        bus.cache_hit   = 1'b1;
        bus.cache_rdata = 32'hDEADBEEF;
        cyc();
        check("rh_rden", bus.cache_rd_en, 1);
        check("rh_stall", bus.cpu_stall, 1);
        check("rh_caddr", bus.cache_addr, 32'h5);
        check("rh_done_early", bus.cpu_done, 0);
        cyc();
        check("rh_done", bus.cpu_done, 1);
        check("rh_rdata", bus.cpu_rdata, 32'hDEADBEEF);
        check("rh_hitcnt", bus.hit_count, 1);
        check("rh_misscnt", bus.miss_count, 0);
        check("rh_stall_done", bus.cpu_stall, 0);
        // cpu_read still held: must not be re-sampled in the done cycle
        cyc();
        check("rh_noresample", bus.cpu_stall, 0);
        check("rh_done_once", bus.cpu_done, 0);
        bus.cpu_read  = 1'b0;
        bus.cache_hit = 1'b0;

        // Read miss, addr 0x13, memory ready in the fourth REFILL cycle
        cyc();
        bus.cpu_read  = 1'b1;
        bus.cpu_addr  = 32'h13;
        bus.mem_rdata = {D3, D2, D1, D0};
        cyc();
        check("rm_rden", bus.cache_rd_en, 1);
        cyc();
        check("rm_memrd1", bus.mem_rd_req, 1);
        check("rm_memaddr", bus.mem_addr, 32'h10);
        check("rm_misscnt", bus.miss_count, 1);
        check("rm_memwr", bus.mem_wr_req, 0);
        cyc();
        check("rm_memrd2", bus.mem_rd_req, 1);
        cyc();
        check("rm_memrd3", bus.mem_rd_req, 1);
        cyc();
        check("rm_memrd4", bus.mem_rd_req, 1);
        bus.mem_ready = 1'b1;
        cyc();
        bus.mem_ready = 1'b0;
        check("rm_fill", bus.cache_fill, 1);
        check("rm_filldata", bus.cache_fill_data, {D3, D2, D1, D0});
        check("rm_memrd_off", bus.mem_rd_req, 0);
        check("rm_done_fill", bus.cpu_done, 0);
        cyc();
        check("rm_done", bus.cpu_done, 1);
        check("rm_rdata", bus.cpu_rdata, D3);
        bus.cpu_read = 1'b0;
        cyc();
        check("rm_idle", bus.cpu_stall, 0);
        check("rm_fill_pulses", fill_pulses, 1);
        check("rm_rdreq_cycles", rd_req_cycles, 4);

        // Write hit then write miss, from a fresh reset
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        check("w_rst_hit", bus.hit_count, 0);
        check("w_rst_miss", bus.miss_count, 0);
        wr_en_base   = wr_en_pulses;
        wr_xfer_base = wr_xfers;
        rd_req_base  = rd_req_cycles;
        bus.cpu_write = 1'b1;
        bus.cpu_addr  = 32'h21;
        bus.cpu_wdata = 32'hA5A5_0001;
        bus.cache_hit = 1'b1;
        cyc();
        check("wh_wren", bus.cache_wr_en, 1);
        check("wh_caddr", bus.cache_addr, 32'h21);
        check("wh_cwdata", bus.cache_wdata, 32'hA5A5_0001);
        cyc();
        check("wh_memwr", bus.mem_wr_req, 1);
        check("wh_memrd", bus.mem_rd_req, 0);
        check("wh_memaddr", bus.mem_addr, 32'h21);
        check("wh_memwdata", bus.mem_wdata, 32'hA5A5_0001);
        check("wh_hitcnt", bus.hit_count, 1);
        bus.mem_ready = 1'b1;
        cyc();
        check("wh_done", bus.cpu_done, 1);
        check("wh_memwr_off", bus.mem_wr_req, 0);
        bus.cpu_write = 1'b0;
        bus.mem_ready = 1'b0;
        bus.cache_hit = 1'b0;
        cyc();
        bus.cpu_write = 1'b1;
        bus.cpu_addr  = 32'h30;
        bus.cpu_wdata = 32'h1234_5678;
        cyc();
        check("wm_wren", bus.cache_wr_en, 0);
        check("wm_rden", bus.cache_rd_en, 1);
        cyc();
        check("wm_memwr", bus.mem_wr_req, 1);
        check("wm_memaddr", bus.mem_addr, 32'h30);
        check("wm_memwdata", bus.mem_wdata, 32'h1234_5678);
        check("wm_misscnt", bus.miss_count, 1);
        cyc();
        check("wm_memwr_wait", bus.mem_wr_req, 1);
        bus.mem_ready = 1'b1;
        cyc();
        check("wm_done", bus.cpu_done, 1);
        bus.cpu_write = 1'b0;
        bus.mem_ready = 1'b0;
        check("w_hitcnt", bus.hit_count, 1);
        check("w_misscnt", bus.miss_count, 1);
        check("w_wren_pulses", wr_en_pulses - wr_en_base, 1);
        check("w_mem_xfers", wr_xfers - wr_xfer_base, 2);

        // Read and write together: treated as a write
        cyc();
        bus.cpu_read  = 1'b1;
        bus.cpu_write = 1'b1;
        bus.cpu_addr  = 32'h44;
        bus.cpu_wdata = 32'h0BAD_CAFE;
        bus.cache_hit = 1'b1;
        cyc();
        check("rw_wren", bus.cache_wr_en, 1);
        cyc();
        check("rw_memwr", bus.mem_wr_req, 1);
        check("rw_memrd", bus.mem_rd_req, 0);
        check("rw_memwdata", bus.mem_wdata, 32'h0BAD_CAFE);
        bus.mem_ready = 1'b1;
        cyc();
        check("rw_done", bus.cpu_done, 1);
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
        bus.mem_ready = 1'b0;
        bus.cache_hit = 1'b0;
        check("rw_no_rdreq", rd_req_cycles - rd_req_base, 0);
        check("rw_hitcnt", bus.hit_count, 2);

        // Reset in the middle of a refill, then a read in the first cycle after release
        cyc();
        bus.cpu_read = 1'b1;
        bus.cpu_addr = 32'h08;
        cyc();
        cyc();
        check("mr_memrd", bus.mem_rd_req, 1);
        check("mr_misscnt", bus.miss_count, 2);
        reset = 1'b0;
        cyc();
        check("mr_stall", bus.cpu_stall, 0);
        check("mr_memrd_off", bus.mem_rd_req, 0);
        check("mr_hitcnt", bus.hit_count, 0);
        check("mr_misscnt0", bus.miss_count, 0);
        check("mr_done", bus.cpu_done, 0);
        check("mr_rdata", bus.cpu_rdata, 0);
        reset = 1'b1;
        bus.cache_hit   = 1'b1;
        bus.cache_rdata = 32'hCAFE_F00D;
        cyc();
        check("mr_accept", bus.cpu_stall, 1);
        check("mr_rden", bus.cache_rd_en, 1);
        check("mr_caddr", bus.cache_addr, 32'h08);
        cyc();
        check("mr_rd_done", bus.cpu_done, 1);
        check("mr_rd_data", bus.cpu_rdata, 32'hCAFE_F00D);
        check("mr_rd_hitcnt", bus.hit_count, 1);
        bus.cpu_read  = 1'b0;
        bus.cache_hit = 1'b0;

        // Hit counter saturation from a preloaded 0xFFFE
        cyc();
        force dut.hit_count_q = 16'hFFFE;
        cyc();
        release dut.hit_count_q;
        check("sat_preload", bus.hit_count, 16'hFFFE);
        for (int k = 0; k < 3; k++) begin
            bus.cpu_read    = 1'b1;
            bus.cpu_addr    = 32'h100 + k;
            bus.cache_hit   = 1'b1;
            bus.cache_rdata = 32'h5A00 + k;
            cyc();
            cyc();
            check("sat_done", bus.cpu_done, 1);
            check("sat_hitcnt", bus.hit_count, 16'hFFFF);
            bus.cpu_read  = 1'b0;
            bus.cache_hit = 1'b0;
            cyc();
        end
        check("sat_misscnt", bus.miss_count, 0);
        check("never_both_req", both_req, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
